// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the 2-bit-opcode datapath.
// Define MEM_WAIT_EN to honour mem_ready with a bounded wait counter and sticky FAULT state.
module multicycle_cu #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic [2:0]       state,
    output logic             busy,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FLT    = 3'd6
    } state_t;

    state_t           cur;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             rdy;
    logic             boundary;

`ifdef MEM_WAIT_EN
    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    logic [WW-1:0] wcnt;
    logic          waiting;

    assign rdy     = mem_ready;
    assign waiting = ((cur == FETCH) || (cur == MEM)) && !mem_ready;
`else
    logic unused_mem_ready;

    assign rdy              = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // An instruction completes in WB, or in the ready cycle of a store's MEM step
    assign boundary = (cur == WB) || ((cur == MEM) && op_q[0] && rdy);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= IDLE;
            op_q      <= 2'b00;
            retired_q <= '0;
        end else begin
            if (boundary)
                retired_q <= retired_q + CNT_W'(1);
            case (cur)
                IDLE:   if (start) cur <= FETCH;
                FETCH:  if (rdy) cur <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    cur  <= EXEC;
                end
                EXEC:   cur <= op_q[1] ? MEM : WB;
                MEM: begin
                    if (rdy) begin
                        if (!op_q[0])
                            cur <= WB;
                        else
                            cur <= stop ? IDLE : FETCH;
                    end
                end
                WB:     cur <= stop ? IDLE : FETCH;
                FLT:    cur <= FLT;
                default: cur <= IDLE;
            endcase
`ifdef MEM_WAIT_EN
            // The (WAIT_MAX+1)th consecutive idle memory cycle gives up
            if (waiting && (wcnt == WW'(WAIT_MAX)))
                cur <= FLT;
`endif
        end
    end

`ifdef MEM_WAIT_EN
    always_ff @(posedge clk) begin
        if (reset)
            wcnt <= '0;
        else if (waiting)
            wcnt <= wcnt + WW'(1);
        else
            wcnt <= '0;
    end
`endif

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = 2'b00;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                PCWrite = rdy;
                IRWrite = rdy;
            end
            EXEC: begin
                case (op_q)
                    2'b00: begin
                        ALUSrc = 1'b0;
                        ALUOp  = 2'b10;
                    end
                    2'b01: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    default: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b00;
                    end
                endcase
            end
            MEM: begin
                ALUSrc   = 1'b1;
                MemRead  = !op_q[0];
                MemWrite = op_q[0];
            end
            WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == 2'b00);
                MemToReg = (op_q == 2'b10);
            end
            default: ;
        endcase
    end

    assign state      = cur;
    assign busy       = (cur != IDLE) && (cur != FLT);
    assign instr_done = boundary;
    assign retired    = retired_q;
`ifdef MEM_WAIT_EN
    assign fault      = (cur == FLT);
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Table-driven bench for multicycle_cu: one cycle per row, outputs compared before each rising edge.
// A second instance with CNT_W=2 runs in lockstep to exercise counter wrap.
module tb_multicycle_cu;

    logic clk = 1'b0;
    logic reset, start, stop, mem_ready;
    logic [1:0] opcode;

    logic pcw1, irw1, rd1, as1, mtr1, rw1, mr1, mw1, busy1, done1, flt1;
    logic [1:0]  aop1;
    logic [2:0]  st1;
    logic [15:0] ret1;
    logic pcw2, irw2, rd2, as2, mtr2, rw2, mr2, mw2, busy2, done2, flt2;
    logic [1:0]  aop2;
    logic [2:0]  st2;
    logic [1:0]  ret2;

    always #5 clk = ~clk;

    multicycle_cu #(.CNT_W(16), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .opcode(opcode),
        .mem_ready(mem_ready), .PCWrite(pcw1), .IRWrite(irw1), .RegDst(rd1),
        .ALUSrc(as1), .MemToReg(mtr1), .RegWrite(rw1), .MemRead(mr1),
        .MemWrite(mw1), .ALUOp(aop1), .state(st1), .busy(busy1),
        .instr_done(done1), .retired(ret1), .fault(flt1)
    );

    multicycle_cu #(.CNT_W(2), .WAIT_MAX(15)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .opcode(opcode),
        .mem_ready(mem_ready), .PCWrite(pcw2), .IRWrite(irw2), .RegDst(rd2),
        .ALUSrc(as2), .MemToReg(mtr2), .RegWrite(rw2), .MemRead(mr2),
        .MemWrite(mw2), .ALUOp(aop2), .state(st2), .busy(busy2),
        .instr_done(done2), .retired(ret2), .fault(flt2)
    );

    logic [9:0] strb1, strb2;
    assign strb1 = {pcw1, irw1, rd1, as1, mtr1, rw1, mr1, mw1, aop1};
    assign strb2 = {pcw2, irw2, rd2, as2, mtr2, rw2, mr2, mw2, aop2};

    // Strobe bundles {PCWrite,IRWrite,RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,ALUOp}
    localparam logic [9:0] N  = 10'b0000000000;
    localparam logic [9:0] F  = 10'b1100001000;
    localparam logic [9:0] FW = 10'b0000001000;
    localparam logic [9:0] ER = 10'b0000000010;
    localparam logic [9:0] EI = 10'b0001000011;
    localparam logic [9:0] EM = 10'b0001000000;
    localparam logic [9:0] ML = 10'b0001001000;
    localparam logic [9:0] MS = 10'b0001000100;
    localparam logic [9:0] WR = 10'b0010010000;
    localparam logic [9:0] WI = 10'b0000010000;
    localparam logic [9:0] WL = 10'b0000110000;

    typedef struct {
        logic        rst, go, stp;
        logic [1:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic [9:0]  strb;
        logic        done;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    task automatic add(input logic rst, input logic go, input logic stp, input logic [1:0] op,
                       input logic rdy, input logic [2:0] st, input logic [9:0] strb,
                       input logic done, input logic [15:0] ret);
        vec_t v;
        v.rst = rst; v.go = go; v.stp = stp; v.op = op; v.rdy = rdy;
        v.st = st; v.strb = strb; v.done = done; v.ret = ret;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        logic exp_busy, exp_flt;
        reset = 1'b1; start = 1'b0; stop = 1'b0; opcode = 2'b00; mem_ready = 1'b1;

        //   rst go stp op     rdy st    strb done ret
        add(1, 0, 0, 2'b00, 1, 3'd0, N,  0, 0);   // reset state
        add(0, 0, 0, 2'b00, 1, 3'd0, N,  0, 0);
        add(0, 1, 0, 2'b00, 1, 3'd0, N,  0, 0);   // R-format
        add(0, 0, 0, 2'b00, 1, 3'd1, F,  0, 0);
        add(0, 0, 0, 2'b00, 1, 3'd2, N,  0, 0);
        add(0, 0, 0, 2'b11, 1, 3'd3, ER, 0, 0);   // opcode changes after DECODE
        add(0, 0, 0, 2'b11, 1, 3'd5, WR, 1, 0);
        add(0, 0, 0, 2'b01, 1, 3'd1, F,  0, 1);   // I-ALU
        add(0, 0, 0, 2'b01, 1, 3'd2, N,  0, 1);
        add(0, 0, 0, 2'b01, 1, 3'd3, EI, 0, 1);
        add(0, 0, 0, 2'b01, 1, 3'd5, WI, 1, 1);
        add(0, 0, 0, 2'b10, 1, 3'd1, F,  0, 2);   // LW
        add(0, 0, 0, 2'b10, 1, 3'd2, N,  0, 2);
        add(0, 0, 0, 2'b10, 1, 3'd3, EM, 0, 2);
        add(0, 0, 0, 2'b10, 1, 3'd4, ML, 0, 2);
        add(0, 0, 0, 2'b10, 1, 3'd5, WL, 1, 2);
        add(0, 0, 0, 2'b11, 1, 3'd1, F,  0, 3);   // SW, stop at its boundary
        add(0, 0, 0, 2'b11, 1, 3'd2, N,  0, 3);
        add(0, 0, 0, 2'b11, 1, 3'd3, EM, 0, 3);
        add(0, 0, 1, 2'b11, 1, 3'd4, MS, 1, 3);
        add(0, 0, 0, 2'b00, 1, 3'd0, N,  0, 4);   // small counter wraps here
        add(0, 1, 0, 2'b00, 1, 3'd0, N,  0, 4);
        add(0, 0, 1, 2'b00, 1, 3'd1, F,  0, 4);   // stop mid-instruction has no effect
        add(0, 0, 1, 2'b00, 1, 3'd2, N,  0, 4);
        add(0, 0, 1, 2'b00, 1, 3'd3, ER, 0, 4);
        add(0, 0, 1, 2'b00, 1, 3'd5, WR, 1, 4);
        add(0, 1, 1, 2'b11, 1, 3'd0, N,  0, 5);   // stop ignored in IDLE
        add(0, 0, 0, 2'b11, 1, 3'd1, F,  0, 5);
        add(0, 0, 0, 2'b11, 1, 3'd2, N,  0, 5);
        add(0, 0, 0, 2'b11, 1, 3'd3, EM, 0, 5);
        add(1, 0, 0, 2'b11, 1, 3'd4, MS, 1, 5);   // reset mid-MEM
        add(0, 0, 0, 2'b00, 1, 3'd0, N,  0, 0);
`ifdef MEM_WAIT_EN
        add(0, 1, 0, 2'b11, 1, 3'd0, N,  0, 0);   // SW with waits
        add(0, 0, 0, 2'b11, 0, 3'd1, FW, 0, 0);
        add(0, 0, 0, 2'b11, 1, 3'd1, F,  0, 0);
        add(0, 0, 0, 2'b11, 1, 3'd2, N,  0, 0);
        add(0, 0, 0, 2'b11, 1, 3'd3, EM, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 2'b11, 0, 3'd4, MS, 0, 0);
        add(0, 0, 1, 2'b11, 1, 3'd4, MS, 1, 0);
        add(0, 1, 0, 2'b10, 1, 3'd0, N,  0, 1);   // LW, 15 waits in each of FETCH and MEM
        for (int k = 0; k < 15; k++)
            add(0, 0, 0, 2'b10, 0, 3'd1, FW, 0, 1);
        add(0, 0, 0, 2'b10, 1, 3'd1, F,  0, 1);
        add(0, 0, 0, 2'b10, 1, 3'd2, N,  0, 1);
        add(0, 0, 0, 2'b10, 1, 3'd3, EM, 0, 1);
        for (int k = 0; k < 15; k++)
            add(0, 0, 0, 2'b10, 0, 3'd4, ML, 0, 1);
        add(0, 0, 0, 2'b10, 1, 3'd4, ML, 0, 1);
        add(0, 0, 1, 2'b10, 1, 3'd5, WL, 1, 1);
        add(0, 1, 0, 2'b00, 1, 3'd0, N,  0, 2);   // timeout in FETCH
        for (int k = 0; k < 16; k++)
            add(0, 0, 0, 2'b00, 0, 3'd1, FW, 0, 2);
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 2'b00, 1, 3'd6, N,  0, 2);
        add(1, 0, 0, 2'b00, 1, 3'd6, N,  0, 2);
        add(0, 0, 0, 2'b00, 1, 3'd0, N,  0, 0);
`else
        add(0, 1, 0, 2'b00, 0, 3'd0, N,  0, 0);   // mem_ready ignored
        add(0, 0, 0, 2'b00, 0, 3'd1, F,  0, 0);
        add(0, 0, 0, 2'b00, 0, 3'd2, N,  0, 0);
        add(0, 0, 0, 2'b00, 0, 3'd3, ER, 0, 0);
        add(0, 0, 1, 2'b00, 0, 3'd5, WR, 1, 0);
        add(0, 0, 0, 2'b00, 0, 3'd0, N,  0, 1);
`endif

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; start = tbl[i].go; stop = tbl[i].stp;
            opcode = tbl[i].op; mem_ready = tbl[i].rdy;
            #1;
            exp_busy = (tbl[i].st != 3'd0) && (tbl[i].st != 3'd6);
            exp_flt  = (tbl[i].st == 3'd6);
            chk("state",    i, {13'd0, st1},   {13'd0, tbl[i].st});
            chk("strobes",  i, {6'd0, strb1},  {6'd0, tbl[i].strb});
            chk("busy",     i, {15'd0, busy1}, {15'd0, exp_busy});
            chk("done",     i, {15'd0, done1}, {15'd0, tbl[i].done});
            chk("fault",    i, {15'd0, flt1},  {15'd0, exp_flt});
            chk("retired",  i, ret1,           tbl[i].ret);
            chk("state2",   i, {13'd0, st2},   {13'd0, tbl[i].st});
            chk("strobes2", i, {6'd0, strb2},  {6'd0, tbl[i].strb});
            chk("busy2",    i, {15'd0, busy2}, {15'd0, exp_busy});
            chk("done2",    i, {15'd0, done2}, {15'd0, tbl[i].done});
            chk("fault2",   i, {15'd0, flt2},  {15'd0, exp_flt});
            chk("retired2", i, {14'd0, ret2},  {14'd0, tbl[i].ret[1:0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
